// File: rtl/logic_gate_pipe_pkg.sv
// Shared types and constants for the logic gate pipeline.
// Holds the operation encoding, the delivered-beat counter width,
// and the legal ranges for the WIDTH and STAGES parameters.
package logic_gate_pipe_pkg;

  typedef enum logic [2:0] {
    OP_NAND   = 3'd0,
    OP_AND    = 3'd1,
    OP_NOR    = 3'd2,
    OP_OR     = 3'd3,
    OP_XOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_PASS_A = 3'd6,
    OP_NOT_A  = 3'd7
  } op_e;

  localparam int CNT_W      = 16;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;
  localparam int WIDTH_MIN  = 1;
  localparam int WIDTH_MAX  = 64;

endpackage

// File: rtl/logic_gate_pipe_stage.sv
// Single elastic register stage: one beat plus a valid bit.
// Latency 1 cycle; full throughput when downstream keeps up.
// Backpressure: ready = empty or draining this cycle; flush forces ready low and empties the stage.
module logic_gate_pipe_stage #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         in_vld_i,
  output logic         in_rdy_o,
  input  logic [W-1:0] in_dat_i,
  output logic         out_vld_o,
  input  logic         out_rdy_i,
  output logic [W-1:0] out_dat_o
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;
  logic         load;

  // Load when empty or when the held beat leaves this cycle; flush wins over everything.
  always_comb begin
    in_rdy_o = (!vld_q || out_rdy_i) && !flush_i;
    load     = in_vld_i && in_rdy_o;
    vld_d    = vld_q;
    dat_d    = dat_q;
    if (flush_i) begin
      vld_d = 1'b0;
    end else if (load) begin
      vld_d = 1'b1;
      dat_d = in_dat_i;
    end else if (out_rdy_i) begin
      vld_d = 1'b0;
    end
  end

  // State register; data is cleared too so the last stage presents y=0 and flags=0 in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_vld_o = vld_q;
  assign out_dat_o = dat_q;

endmodule

// File: rtl/logic_gate_pipe.sv
// Bitwise two-operand logic unit followed by a chain of elastic register stages.
// Latency STAGES cycles from accept to out_valid, one beat per cycle sustained.
// Backpressure: in_ready falls when the chain is full and out_ready is low, and during flush.
module logic_gate_pipe
  import logic_gate_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_all_zero,
  output logic             y_all_one,
  output logic [CNT_W-1:0] out_count
);

  // Each stage carries {all_one, all_zero, result} so the flags travel with y.
  localparam int DW = WIDTH + 2;

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("logic_gate_pipe: WIDTH=%0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
  end
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("logic_gate_pipe: STAGES=%0d outside %0d..%0d", STAGES, STAGES_MIN, STAGES_MAX);
  end

  logic [WIDTH-1:0] res_d;
  logic [DW-1:0]    beat_d;
  logic [DW-1:0]    last_dat;
  logic             deliver;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  // Operation decode; all compute happens here, ahead of the first register.
  always_comb begin
    res_d = '0;
    case (op_e'(op))
      OP_NAND:   res_d = ~(a & b);
      OP_AND:    res_d = a & b;
      OP_NOR:    res_d = ~(a | b);
      OP_OR:     res_d = a | b;
      OP_XOR:    res_d = a ^ b;
      OP_XNOR:   res_d = ~(a ^ b);
      OP_PASS_A: res_d = a;
      OP_NOT_A:  res_d = ~a;
      default:   res_d = '0;
    endcase
  end

  // For WIDTH=1 the reductions collapse to the single bit and its inverse.
  assign beat_d = {&res_d, ~|res_d, res_d};

  for (genvar i = 0; i < STAGES; i++) begin : g_stg
    logic          s_in_vld, s_in_rdy, s_out_vld, s_out_rdy;
    logic [DW-1:0] s_in_dat, s_out_dat;

    if (i == 0) begin : g_head
      assign s_in_vld = in_valid;
      assign s_in_dat = beat_d;
    end else begin : g_link_in
      assign s_in_vld = g_stg[i-1].s_out_vld;
      assign s_in_dat = g_stg[i-1].s_out_dat;
    end

    if (i == STAGES - 1) begin : g_tail
      assign s_out_rdy = out_ready;
    end else begin : g_link_out
      assign s_out_rdy = g_stg[i+1].s_in_rdy;
    end

    logic_gate_pipe_stage #(.W(DW)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush_i   (flush),
      .in_vld_i  (s_in_vld),
      .in_rdy_o  (s_in_rdy),
      .in_dat_i  (s_in_dat),
      .out_vld_o (s_out_vld),
      .out_rdy_i (s_out_rdy),
      .out_dat_o (s_out_dat)
    );
  end

  assign in_ready   = g_stg[0].s_in_rdy;
  assign out_valid  = g_stg[STAGES-1].s_out_vld;
  assign last_dat   = g_stg[STAGES-1].s_out_dat;
  assign y          = last_dat[WIDTH-1:0];
  assign y_all_zero = last_dat[WIDTH];
  assign y_all_one  = last_dat[WIDTH+1];

  // Delivered-beat counter; a delivery in a flush cycle still counts, and it wraps freely.
  always_comb begin
    deliver     = out_valid && out_ready;
    out_count_d = out_count_q;
    if (deliver) begin
      out_count_d = out_count_q + CNT_W'(1);
    end
  end

  // Counter register; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_count_q <= '0;
    end else begin
      out_count_q <= out_count_d;
    end
  end

  assign out_count = out_count_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed bench for logic_gate_pipe at WIDTH=8, STAGES=2.
// Table of single-beat vectors, then streaming, backpressure, flush, reset and counter-wrap sequences.
module tb_logic_gate_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic        y_all_zero, y_all_one;
  logic [7:0]  a, b, y;
  logic [2:0]  op;
  logic [15:0] out_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] y;
    logic       z;
    logic       o;
  } vec_t;

  vec_t        vecs [16];
  logic [7:0]  exp_s [6];
  logic [15:0] exp_w [3];
  logic [7:0]  got [$];
  int          cyc [$];

  always #5 clk = ~clk;

  logic_gate_pipe #(.WIDTH(8), .STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .op         (op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y          (y),
    .y_all_zero (y_all_zero),
    .y_all_one  (y_all_one),
    .out_count  (out_count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, k, seen, acc;

    vecs[0]  = '{8'hF0, 8'hCC, 3'd0, 8'h3F, 1'b0, 1'b0};
    vecs[1]  = '{8'hAA, 8'h0F, 3'd0, 8'hF5, 1'b0, 1'b0};
    vecs[2]  = '{8'hAA, 8'h0F, 3'd1, 8'h0A, 1'b0, 1'b0};
    vecs[3]  = '{8'hAA, 8'h0F, 3'd2, 8'h50, 1'b0, 1'b0};
    vecs[4]  = '{8'hAA, 8'h0F, 3'd3, 8'hAF, 1'b0, 1'b0};
    vecs[5]  = '{8'hAA, 8'h0F, 3'd4, 8'hA5, 1'b0, 1'b0};
    vecs[6]  = '{8'hAA, 8'h0F, 3'd5, 8'h5A, 1'b0, 1'b0};
    vecs[7]  = '{8'h3C, 8'hFF, 3'd6, 8'h3C, 1'b0, 1'b0};
    vecs[8]  = '{8'h3C, 8'h00, 3'd7, 8'hC3, 1'b0, 1'b0};
    vecs[9]  = '{8'hFF, 8'hFF, 3'd1, 8'hFF, 1'b0, 1'b1};
    vecs[10] = '{8'h55, 8'h55, 3'd4, 8'h00, 1'b1, 1'b0};
    vecs[11] = '{8'h00, 8'h00, 3'd0, 8'hFF, 1'b0, 1'b1};
    vecs[12] = '{8'hFF, 8'h00, 3'd2, 8'h00, 1'b1, 1'b0};
    vecs[13] = '{8'h00, 8'h5A, 3'd7, 8'hFF, 1'b0, 1'b1};
    vecs[14] = '{8'h00, 8'hFF, 3'd6, 8'h00, 1'b1, 1'b0};
    vecs[15] = '{8'h12, 8'h34, 3'd5, 8'hD9, 1'b0, 1'b0};
    exp_s = '{8'hF5, 8'h0A, 8'h50, 8'hAF, 8'hA5, 8'h5A};
    exp_w = '{16'hFFFF, 16'h0000, 16'h0001};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0;

    // Reset state
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_y", 64'(y), 64'(0));
    chk("rst_zero", 64'(y_all_zero), 64'(0));
    chk("rst_one", 64'(y_all_one), 64'(0));
    chk("rst_count", 64'(out_count), 64'(0));
    @(posedge clk); #3; rst = 1'b0;
    tick();
    chk("rel_in_ready", 64'(in_ready), 64'(1));

    // Single beats from the table: latency, result, flags
    for (int i = 0; i < 16; i++) begin
      a = vecs[i].a; b = vecs[i].b; op = vecs[i].op; in_valid = 1'b1;
      #4;
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(1));
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin tick(); lat++; end
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(2));
      chk($sformatf("vec%0d_y", i), 64'(y), 64'(vecs[i].y));
      chk($sformatf("vec%0d_zero", i), 64'(y_all_zero), 64'(vecs[i].z));
      chk($sformatf("vec%0d_one", i), 64'(y_all_one), 64'(vecs[i].o));
      tick();
    end
    chk("count_after_table", 64'(out_count), 64'(16));

    // Back-to-back stream, ops 0..5
    got.delete(); cyc.delete();
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 6); op = 3'(c); a = 8'hAA; b = 8'h0F;
      #4;
      if (c < 6) chk($sformatf("stream_in_ready%0d", c), 64'(in_ready), 64'(1));
      if (out_valid) begin got.push_back(y); cyc.push_back(c); end
      tick();
    end
    in_valid = 1'b0;
    chk("stream_count", 64'(got.size()), 64'(6));
    for (int j = 0; j < 6; j++) begin
      if (j < got.size()) begin
        chk($sformatf("stream_y%0d", j), 64'(got[j]), 64'(exp_s[j]));
        chk($sformatf("stream_cycle%0d", j), 64'(cyc[j]), 64'(j + 2));
      end
    end
    chk("count_after_stream", 64'(out_count), 64'(22));

    // Backpressure: 4 beats offered while out_ready is low
    out_ready = 1'b0; k = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; a = 8'((k + 1) * 17); b = 8'h00; op = 3'd6;
      #4;
      if (c == 2 || c == 4) chk($sformatf("bp_in_ready%0d", c), 64'(in_ready), 64'(0));
      if (c >= 2) begin
        chk($sformatf("bp_hold_vld%0d", c), 64'(out_valid), 64'(1));
        chk($sformatf("bp_hold_y%0d", c), 64'(y), 64'(8'h11));
      end
      if (in_ready) k++;
      tick();
    end
    chk("bp_accepted_while_stalled", 64'(k), 64'(2));
    out_ready = 1'b1; got.delete();
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      in_valid = (k < 4); a = 8'((k + 1) * 17);
      #4;
      if (out_valid) got.push_back(y);
      if (in_valid && in_ready) k++;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_delivered", 64'(got.size()), 64'(4));
    for (int j = 0; j < 4; j++) begin
      if (j < got.size()) chk($sformatf("bp_y%0d", j), 64'(got[j]), 64'(8'((j + 1) * 17)));
    end
    tick();
    chk("count_after_bp", 64'(out_count), 64'(26));

    // Flush with two beats in flight and a beat offered in the flush cycle
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; a = 8'(8'h21 + c); op = 3'd6;
      #4;
      chk($sformatf("fl_fill_rdy%0d", c), 64'(in_ready), 64'(1));
      tick();
    end
    flush = 1'b1; in_valid = 1'b1; a = 8'h77;
    #4;
    chk("fl_in_ready", 64'(in_ready), 64'(0));
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #4;
    chk("fl_out_valid", 64'(out_valid), 64'(0));
    chk("fl_count", 64'(out_count), 64'(26));
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("fl_no_leftover", 64'(seen), 64'(0));

    // Flush in the same cycle a result is delivered: delivery is counted
    in_valid = 1'b1; a = 8'h99; op = 3'd6;
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    #4;
    chk("fl2_out_valid", 64'(out_valid), 64'(1));
    tick();
    flush = 1'b0;
    #4;
    chk("fl2_count", 64'(out_count), 64'(27));
    chk("fl2_out_valid_after", 64'(out_valid), 64'(0));
    tick();

    // Asynchronous reset with a full pipe
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; a = 8'(8'h41 + c); op = 3'd6;
      #4;
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_vld", 64'(out_valid), 64'(1));
    #3; rst = 1'b1; #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_count", 64'(out_count), 64'(0));
    chk("arst_y", 64'(y), 64'(0));
    chk("arst_flags", 64'({y_all_zero, y_all_one}), 64'(0));
    @(posedge clk); #3; rst = 1'b0; out_ready = 1'b1;
    tick();
    chk("arst_rel_in_ready", 64'(in_ready), 64'(1));
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("arst_no_partial", 64'(seen), 64'(0));

    // Counter wrap: 65534 deliveries, then three more
    in_valid = 1'b1; a = 8'hFF; b = 8'hFF; op = 3'd1; acc = 0;
    for (int c = 0; c < 70000 && acc < 65534; c++) begin
      #4;
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    chk("wrap_accepted", 64'(acc), 64'(65534));
    for (int c = 0; c < 4; c++) tick();
    chk("wrap_preload", 64'(out_count), 64'(16'hFFFE));
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1;
      #4;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin tick(); lat++; end
      chk($sformatf("wrap_vld%0d", j), 64'(out_valid), 64'(1));
      tick();
      chk($sformatf("wrap_count%0d", j), 64'(out_count), 64'(exp_w[j]));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
